tick_timer_controller: RTL and testbench

Programmable timebase controller that converts the 100 MHz board clock into single-cycle `tick` enables of configurable period and count. It replaces free-running divided clocks with a sequenced, start/stop/pause-able tick source that other logic can use as a clock enable. It supports one-shot and periodic runs and reports run completion. It sits between the top level (buttons/FSMs issuing commands) and any logic needing 50 ms-class timing.

---
 rtl/tick_timer_controller_if.sv | 14 +
 rtl/tick_timer_controller.sv | 68 ++++++
 tb/tb_tick_timer_controller.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/tick_timer_controller_if.sv
// tick_timer_controller_if: configuration handshake between a command source and the tick timer.
interface tick_timer_controller_if #(
  parameter int DIV_W = 32,
  parameter int CNT_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_ticks;
  logic             cfg_periodic;
  logic             cfg_err;
  modport master (output cfg_valid, cfg_div, cfg_ticks, cfg_periodic, input cfg_ready, cfg_err);
  modport slave (input cfg_valid, cfg_div, cfg_ticks, cfg_periodic, output cfg_ready, cfg_err);
endinterface

// File: rtl/tick_timer_controller.sv
// tick_timer_controller: sequenced one-shot/periodic tick-enable source with pause, stop and completion pulse.
module tick_timer_controller #(
  parameter int          DIV_W       = 32,
  parameter int          CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 5000000
) (
  input  logic                        clock,
  input  logic                        reset_n,
  tick_timer_controller_if.slave      cfg,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        pause,
  output logic                        tick,
  output logic                        done,
  output logic                        busy,
  output logic [CNT_W-1:0]            ticks_left
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [DIV_W-1:0] div_reg, cnt;
  logic [CNT_W-1:0] ticks_reg;
  logic periodic_reg, hs, bad, go, wrap;
  assign hs = cfg.cfg_valid && state == IDLE;
  assign bad = cfg.cfg_div < DIV_W'(2) || cfg.cfg_ticks == '0;
  assign go = state == IDLE && start && !(hs && bad);
  assign wrap = state == RUN && !stop && !pause && cnt == div_reg - 1'b1;
  assign cfg.cfg_ready = state == IDLE;
  assign busy = state == RUN;
  // a one-shot stays in RUN through its final tick cycle so busy drops the cycle after done
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (go ? RUN : IDLE) : ((stop || (done && !periodic_reg)) ? IDLE : RUN);
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      div_reg      <= DIV_W'(DEFAULT_DIV);
      ticks_reg    <= CNT_W'(1);
      periodic_reg <= 1'b0;
      cnt          <= '0;
      tick         <= 1'b0;
      done         <= 1'b0;
      cfg.cfg_err  <= 1'b0;
      ticks_left   <= '0;
    end else begin
      state       <= state_nx;
      cfg.cfg_err <= hs && bad;
      tick        <= wrap;
      done        <= wrap && ticks_left == CNT_W'(1);
      if (hs && !bad) begin
        div_reg      <= cfg.cfg_div;
        ticks_reg    <= cfg.cfg_ticks;
        periodic_reg <= cfg.cfg_periodic;
      end
      if (go) begin
        cnt        <= '0;
        ticks_left <= hs ? cfg.cfg_ticks : ticks_reg;
      end else if (state == RUN && state_nx == IDLE) begin
        cnt        <= '0;
        ticks_left <= '0;
      end else if (state == RUN && !pause) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
        if (wrap)
          ticks_left <= ticks_left != CNT_W'(1) ? ticks_left - 1'b1 : (periodic_reg ? ticks_reg : '0);
      end
    end
  end
endmodule

// File: tb/tb_tick_timer_controller.sv
// tb_tick_timer_controller: directed and randomized checks of the tick timer against an arithmetic model.
module tb_tick_timer_controller;
  localparam int DIV_W = 32;
  localparam int CNT_W = 16;
  logic clock = 0, reset_n = 0, start = 0, stop = 0, pause = 0;
  logic tick, done, busy;
  logic [CNT_W-1:0] ticks_left;
  logic [CNT_W+3:0] got, exp;
  int total = 0, bad = 0;
  tick_timer_controller_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) cfg ();
  tick_timer_controller #(.DIV_W(DIV_W), .CNT_W(CNT_W), .DEFAULT_DIV(10)) dut (
    .clock(clock), .reset_n(reset_n), .cfg(cfg), .start(start), .stop(stop), .pause(pause),
    .tick(tick), .done(done), .busy(busy), .ticks_left(ticks_left)
  );
  always #5 clock = ~clock;

  task step;
    @(posedge clock);
    #1;
  endtask

  task configure(input int d, input int t, input int p);
    cfg.cfg_valid = 1; cfg.cfg_div = DIV_W'(d); cfg.cfg_ticks = CNT_W'(t); cfg.cfg_periodic = p[0];
    step;
    cfg.cfg_valid = 0;
  endtask

  task test_reset;
    reset_n = 0;
    repeat (3) step;
    got = {tick, done, busy, cfg.cfg_ready, ticks_left};
    exp = {4'b0001, CNT_W'(0)};
    total++;
    if (got !== exp || cfg.cfg_err !== 1'b0) begin
      bad++; $display("FAIL reset_values got=%h err=%b exp=%h err=0", got, cfg.cfg_err, exp);
    end
    reset_n = 1; start = 1; step; start = 0;
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) step;
      got = {tick, done, busy, cfg.cfg_ready, ticks_left};
      exp = {c == 10, c == 10, c <= 10, c > 10, CNT_W'(c < 10 ? 1 : 0)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL default_run c=%0d got=%h exp=%h", c, got, exp); end
    end
  endtask

  task test_one_shot;
    configure(4, 3, 0);
    total++;
    if (cfg.cfg_err !== 1'b0) begin bad++; $display("FAIL one_shot_cfg_err got=%b exp=0", cfg.cfg_err); end
    start = 1; step; start = 0;
    for (int c = 0; c <= 13; c++) begin
      if (c > 0) step;
      got = {tick, done, busy, cfg.cfg_ready, ticks_left};
      exp = {c > 0 && c % 4 == 0 && c <= 12, c == 12, c <= 12, c > 12,
             CNT_W'(c < 4 ? 3 : c < 8 ? 2 : c < 12 ? 1 : 0)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL one_shot c=%0d got=%h exp=%h", c, got, exp); end
    end
  endtask

  task test_periodic_stop;
    configure(3, 2, 1);
    start = 1; step; start = 0;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) step;
      got = {tick, done, busy, cfg.cfg_ready, ticks_left};
      exp = {c == 3 || c == 6, c == 6, c <= 8, c > 8,
             CNT_W'(c < 3 ? 2 : c < 6 ? 1 : c < 9 ? 2 : 0)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL periodic_stop c=%0d got=%h exp=%h", c, got, exp); end
      stop = c == 8;
    end
  endtask

  task test_pause;
    configure(5, 1, 0);
    start = 1; step; start = 0;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) step;
      got = {tick, done, busy, cfg.cfg_ready, ticks_left};
      exp = {c == 7, c == 7, c <= 7, c > 7, CNT_W'(c < 7 ? 1 : 0)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL pause c=%0d got=%h exp=%h", c, got, exp); end
      pause = c == 1 || c == 2;
    end
    pause = 0;
  endtask

  task test_cfg_reject;
    configure(3, 2, 0);
    configure(1, 5, 1);
    total++;
    if (cfg.cfg_err !== 1'b1) begin bad++; $display("FAIL reject_div got=%b exp=1", cfg.cfg_err); end
    step;
    total++;
    if (cfg.cfg_err !== 1'b0) begin bad++; $display("FAIL reject_pulse_width got=%b exp=0", cfg.cfg_err); end
    configure(4, 0, 1);
    total++;
    if (cfg.cfg_err !== 1'b1) begin bad++; $display("FAIL reject_ticks got=%b exp=1", cfg.cfg_err); end
    cfg.cfg_valid = 1; cfg.cfg_div = '0; cfg.cfg_ticks = 3; start = 1;
    step;
    cfg.cfg_valid = 0; start = 0;
    total++;
    if ({busy, cfg.cfg_err} !== 2'b01) begin
      bad++; $display("FAIL reject_with_start busy,err got=%b exp=01", {busy, cfg.cfg_err});
    end
    step;
    start = 1; step; start = 0;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) step;
      got = {tick, done, busy, cfg.cfg_ready, ticks_left};
      exp = {c == 3 || c == 6, c == 6, c <= 6, c > 6, CNT_W'(c < 3 ? 2 : c < 6 ? 1 : 0)};
      total++;
      if (got !== exp || cfg.cfg_err !== 1'b0) begin
        bad++; $display("FAIL cfg_in_run c=%0d got=%h err=%b exp=%h err=0", c, got, cfg.cfg_err, exp);
      end
      cfg.cfg_valid = c <= 1; cfg.cfg_div = 2; cfg.cfg_ticks = 1; cfg.cfg_periodic = 1;
    end
    cfg.cfg_valid = 0;
  endtask

  task test_cfg_start;
    cfg.cfg_valid = 1; cfg.cfg_div = 6; cfg.cfg_ticks = 1; cfg.cfg_periodic = 0; start = 1;
    step;
    cfg.cfg_valid = 0; start = 0;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) step;
      got = {tick, done, busy, cfg.cfg_ready, ticks_left};
      exp = {c == 6, c == 6, c <= 6 || c == 8, c == 7, CNT_W'(c < 6 || c == 8 ? 1 : 0)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL cfg_start_b2b c=%0d got=%h exp=%h", c, got, exp); end
      start = c == 7;
    end
    stop = 1; step; stop = 0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_stop busy got=%b exp=0", busy); end
  endtask

  task test_random;
    int d, t, p, a, n, lim;
    bit live, ending, pz, et, ed;
    for (int r = 0; r < 12; r++) begin
      d = $urandom_range(2, 6); t = $urandom_range(1, 4); p = $urandom_range(0, 1);
      configure(d, t, p);
      start = 1; step; start = 0;
      a = 0; n = 0; live = 1; ending = 0;
      lim = p != 0 ? $urandom_range(2 * d * t, 3 * d * t) : 200;
      got = {tick, done, busy, cfg.cfg_ready, ticks_left};
      exp = {4'b0010, CNT_W'(t)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL rand_start r=%0d got=%h exp=%h", r, got, exp); end
      for (int c = 1; c <= lim && live; c++) begin
        pz = $urandom_range(0, 3) == 0;
        pause = pz;
        step;
        if (ending) begin live = 0; ending = 0; end
        et = 0; ed = 0;
        if (live && !pz) begin
          a++;
          if (a % d == 0) begin
            et = 1; n++; ed = n % t == 0;
            if (ed && p == 0) ending = 1;
          end
        end
        got = {tick, done, busy, cfg.cfg_ready, ticks_left};
        exp = {et, ed, live, !live, CNT_W'(!live || ending ? 0 : t - n % t)};
        total++;
        if (got !== exp) begin
          bad++; $display("FAIL rand r=%0d d=%0d t=%0d p=%0d c=%0d got=%h exp=%h", r, d, t, p, c, got, exp);
        end
      end
      pause = 0; stop = 1; step; stop = 0;
      got = {tick, done, busy, cfg.cfg_ready, ticks_left};
      exp = {4'b0001, CNT_W'(0)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL rand_stop r=%0d got=%h exp=%h", r, got, exp); end
    end
  endtask

  task test_reset_midrun;
    configure(6, 1, 0);
    start = 1; step; start = 0;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) step;
      got = {tick, done, busy, cfg.cfg_ready, ticks_left};
      exp = c <= 3 ? {4'b0010, CNT_W'(1)} : {4'b0001, CNT_W'(0)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL reset_midrun c=%0d got=%h exp=%h", c, got, exp); end
      reset_n = c != 3;
    end
    start = 1; step; start = 0;
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) step;
      got = {tick, done, busy, cfg.cfg_ready, ticks_left};
      exp = {c == 10, c == 10, c <= 10, c > 10, CNT_W'(c < 10 ? 1 : 0)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL reset_restored c=%0d got=%h exp=%h", c, got, exp); end
    end
  endtask

  initial begin
    cfg.cfg_valid = 0; cfg.cfg_div = '0; cfg.cfg_ticks = '0; cfg.cfg_periodic = 0;
    test_reset;
    test_one_shot;
    test_periodic_stop;
    test_pause;
    test_cfg_reject;
    test_cfg_start;
    test_random;
    test_reset_midrun;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
